// File: rtl/interval_timer_arbiter_pkg.sv
// Shared definitions for the counter10k family: FSM encoding and default counter sizing.
package interval_timer_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefTerminal = 10000;
  localparam int unsigned DefCw       = 16;

endpackage

// File: rtl/interval_timer_arbiter_period_counter.sv
// Wrapping 0..TERMINAL-1 period counter with a registered one-cycle wrap pulse.
module period_counter
  import interval_timer_arbiter_pkg::*;
#(
  parameter int unsigned TERMINAL = DefTerminal,
  parameter int unsigned CW       = DefCw
) (
  input  logic          tick_i,
  input  logic          reset_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] internal_o,
  output logic          reached_o
);

  localparam logic [CW-1:0] Last = CW'(TERMINAL - 1);

  logic [CW-1:0] internal_q, internal_d;
  logic          reached_q, reached_d;

  // Next count: clear dominates enable, so an abort on the last count never pulses reached.
  always_comb begin
    internal_d = internal_q;
    reached_d  = 1'b0;
    if (clr_i) begin
      internal_d = '0;
    end else if (en_i) begin
      if (internal_q == Last) begin
        internal_d = '0;
        reached_d  = 1'b1;
      end else begin
        internal_d = internal_q + CW'(1);
      end
    end
  end

  // Counter state.
  always_ff @(posedge tick_i or posedge reset_i) begin
    if (reset_i) begin
      internal_q <= '0;
      reached_q  <= 1'b0;
    end else begin
      internal_q <= internal_d;
      reached_q  <= reached_d;
    end
  end

  assign internal_o = internal_q;
  assign reached_o  = reached_q;

endmodule

// File: rtl/interval_timer_arbiter.sv
// Round-robin arbiter that lends one period counter to NREQ requesters for len[i] periods each.
module interval_timer_arbiter
  import interval_timer_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned TERMINAL = DefTerminal,
  parameter int unsigned CW       = DefCw,
  parameter int unsigned LENW     = 8
) (
  input  logic                 tick_i,
  input  logic                 reset_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*LENW-1:0] len_i,
  output logic [NREQ-1:0]      grant_o,
  output logic [NREQ-1:0]      done_o,
  output logic                 busy_o,
  output logic                 reached_o,
  output logic [CW-1:0]        internal_o
);

  localparam int unsigned   IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] Last = CW'(TERMINAL - 1);

  // First asserted request strictly after rr, wrapping; lower offsets overwrite later ones.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IdxW-1:0] rr);
    logic [IdxW-1:0] pick;
    int unsigned     j;
    pick = rr;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      j = (32'(rr) + i) % NREQ;
      if (req[j]) pick = IdxW'(j);
    end
    return pick;
  endfunction

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [LENW-1:0] left_q, left_d;

  logic            cnt_clr, cnt_en;
  logic [CW-1:0]   internal;
  logic            owner_req, wrap;
  logic [IdxW-1:0] pick_idx;
  logic [LENW-1:0] pick_len;

  assign owner_req = |(req_i & grant_q);
  assign wrap      = (internal == Last);
  assign pick_idx  = rr_pick(req_i, rr_q);
  assign pick_len  = len_i[32'(pick_idx)*LENW +: LENW];

  period_counter #(
    .TERMINAL(TERMINAL),
    .CW      (CW)
  ) u_period_counter (
    .tick_i    (tick_i),
    .reset_i   (reset_i),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .internal_o(internal),
    .reached_o (reached_o)
  );

  // State register plus all registered arbiter outputs.
  always_ff @(posedge tick_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      done_q  <= '0;
      rr_q    <= IdxW'(NREQ - 1);
      owner_q <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      left_q  <= left_d;
    end
  end

  // Next-state: abort is tested before the wrap so it wins a coincident last count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (|req_i) state_d = StRun;
      StRun: begin
        if (!owner_req) begin
          state_d = StIdle;
        end else if (wrap && (left_q == LENW'(1))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and counter control for each state.
  always_comb begin
    grant_d = grant_q;
    done_d  = '0;
    rr_d    = rr_q;
    owner_d = owner_q;
    left_d  = left_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          grant_d = NREQ'(1) << pick_idx;
          owner_d = pick_idx;
          left_d  = (pick_len == '0) ? LENW'(1) : pick_len;
          cnt_clr = 1'b1;
        end
      end
      StRun: begin
        if (!owner_req) begin
          grant_d = '0;
          rr_d    = owner_q;
          left_d  = '0;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (wrap) begin
            left_d = left_q - LENW'(1);
            if (left_q == LENW'(1)) done_d = grant_q;
          end
        end
      end
      StDone: begin
        grant_d = '0;
        rr_d    = owner_q;
        cnt_clr = 1'b1;
      end
      default: begin
        grant_d = '0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Outputs straight from registers.
  always_comb begin
    grant_o    = grant_q;
    done_o     = done_q;
    busy_o     = (state_q != StIdle);
    internal_o = internal;
  end

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Directed bench for interval_timer_arbiter with a short counter period.
module tb_interval_timer_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned TERMINAL = 10;
  localparam int unsigned CW       = 16;
  localparam int unsigned LENW     = 8;

  logic                 tick;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*LENW-1:0] len;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic                 reached;
  logic [CW-1:0]        internal;

  int checks = 0;
  int errors = 0;

  interval_timer_arbiter #(
    .NREQ    (NREQ),
    .TERMINAL(TERMINAL),
    .CW      (CW),
    .LENW    (LENW)
  ) dut (
    .tick_i    (tick),
    .reset_i   (reset),
    .req_i     (req),
    .len_i     (len),
    .grant_o   (grant),
    .done_o    (done),
    .busy_o    (busy),
    .reached_o (reached),
    .internal_o(internal)
  );

  initial tick = 1'b0;
  always #5 tick = ~tick;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  grant;
    int          cycles;
    int          nreached;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge tick);
    @(negedge tick);
  endtask

  // Steps until done pulses (bounded), counting RUN cycles, reached pulses and peak count.
  task automatic run_to_done(output int n, output int rc, output int maxi);
    n = 0;
    rc = 0;
    maxi = 0;
    while (done == '0 && n < 400) begin
      step();
      n++;
      if (reached) rc++;
      if (int'(internal) > maxi) maxi = int'(internal);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rc, mx;
    logic [3:0] rr_exp[5];

    vecs[0] = '{req: 4'b0010, len: 32'h0000_0300, grant: 4'b0010, cycles: 30, nreached: 3};
    vecs[1] = '{req: 4'b0100, len: 32'h0000_0000, grant: 4'b0100, cycles: 10, nreached: 1};
    vecs[2] = '{req: 4'b0001, len: 32'h0000_0002, grant: 4'b0001, cycles: 20, nreached: 2};
    vecs[3] = '{req: 4'b1000, len: 32'h0100_0000, grant: 4'b1000, cycles: 10, nreached: 1};
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;

    // Reset state
    reset = 1'b1;
    req   = '0;
    len   = '0;
    repeat (2) @(negedge tick);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_reached", 32'(reached), 32'h0);
    chk("rst_internal", 32'(internal), 32'h0);
    reset = 1'b0;
    step();
    chk("idle_grant", 32'(grant), 32'h0);

    // Reset in the middle of a RUN, asynchronously
    req = 4'b0100;
    len = 32'h0003_0000;
    step();
    chk("mid_grant", 32'(grant), 32'h4);
    repeat (15) step();
    chk("mid_internal", 32'(internal), 32'd5);
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_internal", 32'(internal), 32'h0);
    chk("async_done", 32'(done), 32'h0);
    @(negedge tick);
    req   = 4'b1111;
    len   = 32'h0101_0101;
    reset = 1'b0;
    step();

    // Round robin with all requests held
    chk("rr_grant0", 32'(grant), 32'(rr_exp[0]));
    for (int k = 0; k < 4; k++) begin
      run_to_done(n, rc, mx);
      chk("rr_cycles", 32'(n), 32'd10);
      chk("rr_done", 32'(done), 32'(rr_exp[k]));
      step();
      chk("rr_gap_grant", 32'(grant), 32'h0);
      step();
      chk("rr_next_grant", 32'(grant), 32'(rr_exp[k+1]));
    end
    req = '0;
    step();
    chk("rr_abort_grant", 32'(grant), 32'h0);
    chk("rr_abort_done", 32'(done), 32'h0);

    // Single-requester transactions
    for (int v = 0; v < 4; v++) begin
      req = vecs[v].req;
      len = vecs[v].len;
      step();
      chk("vec_grant", 32'(grant), 32'(vecs[v].grant));
      chk("vec_internal0", 32'(internal), 32'h0);
      run_to_done(n, rc, mx);
      chk("vec_cycles", 32'(n), 32'(vecs[v].cycles));
      chk("vec_reached", 32'(rc), 32'(vecs[v].nreached));
      chk("vec_done", 32'(done), 32'(vecs[v].grant));
      chk("vec_max_internal", 32'(mx), 32'(TERMINAL - 1));
      req = '0;
      step();
      chk("vec_done_pulse", 32'(done), 32'h0);
      chk("vec_grant_off", 32'(grant), 32'h0);
      chk("vec_busy_off", 32'(busy), 32'h0);
    end

    // Abort mid-interval with a pending requester
    req = 4'b1000;
    len = 32'h0500_0001;
    step();
    chk("abort_grant", 32'(grant), 32'h8);
    req = 4'b1001;
    rc = 0;
    repeat (23) begin
      step();
      if (reached) rc++;
    end
    chk("abort_internal", 32'(internal), 32'd3);
    chk("abort_reached_cnt", 32'(rc), 32'd2);
    req = 4'b0001;
    step();
    chk("abort_grant_off", 32'(grant), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_internal0", 32'(internal), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    step();
    chk("abort_next_grant", 32'(grant), 32'h1);

    // Abort on the last count of the period
    repeat (9) step();
    chk("wrap_internal", 32'(internal), 32'd9);
    req = '0;
    step();
    chk("wrap_abort_reached", 32'(reached), 32'h0);
    chk("wrap_abort_done", 32'(done), 32'h0);
    chk("wrap_abort_grant", 32'(grant), 32'h0);
    chk("wrap_abort_internal", 32'(internal), 32'h0);
    step();
    chk("wrap_late_reached", 32'(reached), 32'h0);
    chk("wrap_late_done", 32'(done), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
